// File: rtl/lcd_ctrl_pkg.sv
// Shared command codes and controller state encoding for the parametrised LCD controller.
package lcd_ctrl_pkg;

    localparam logic [3:0] CmdWrtbk  = 4'd0;
    localparam logic [3:0] CmdUp     = 4'd1;
    localparam logic [3:0] CmdDn     = 4'd2;
    localparam logic [3:0] CmdLf     = 4'd3;
    localparam logic [3:0] CmdRt     = 4'd4;
    localparam logic [3:0] CmdAvg    = 4'd5;
    localparam logic [3:0] CmdMrrX   = 4'd6;
    localparam logic [3:0] CmdMrrY   = 4'd7;
    localparam logic [3:0] CmdMax    = 4'd8;
    localparam logic [3:0] CmdMin    = 4'd9;
    localparam logic [3:0] CmdRotCw  = 4'd10;
    localparam logic [3:0] CmdRotCcw = 4'd11;

    typedef enum logic [1:0] {
        StLoad  = 2'd0,
        StIdle  = 2'd1,
        StWrite = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/lcd_win_alu.sv
// Combinational 2x2 window datapath: average, max/min, mirrors and rotations.
// p1 = top-left, p2 = top-right, p3 = bottom-left, p4 = bottom-right.
module lcd_win_alu import lcd_ctrl_pkg::*; #(
    parameter int unsigned DW = 8
) (
    input  logic [DW-1:0] p1_i,
    input  logic [DW-1:0] p2_i,
    input  logic [DW-1:0] p3_i,
    input  logic [DW-1:0] p4_i,
    input  logic [3:0]    cmd_i,
    output logic [DW-1:0] n1_o,
    output logic [DW-1:0] n2_o,
    output logic [DW-1:0] n3_o,
    output logic [DW-1:0] n4_o,
    output logic          we_o
);

    logic [DW+1:0] sum;
    logic [DW-1:0] avg;
    logic [DW-1:0] max12, max34, max_all;
    logic [DW-1:0] min12, min34, min_all;

    always_comb begin
        sum     = {2'b00, p1_i} + {2'b00, p2_i} + {2'b00, p3_i} + {2'b00, p4_i};
        avg     = DW'(sum >> 2);
        max12   = (p1_i > p2_i) ? p1_i : p2_i;
        max34   = (p3_i > p4_i) ? p3_i : p4_i;
        max_all = (max12 > max34) ? max12 : max34;
        min12   = (p1_i < p2_i) ? p1_i : p2_i;
        min34   = (p3_i < p4_i) ? p3_i : p4_i;
        min_all = (min12 < min34) ? min12 : min34;
    end

    always_comb begin
        n1_o = p1_i;
        n2_o = p2_i;
        n3_o = p3_i;
        n4_o = p4_i;
        we_o = 1'b1;
        case (cmd_i)
            CmdAvg: begin
                n1_o = avg;
                n2_o = avg;
                n3_o = avg;
                n4_o = avg;
            end
            CmdMrrX: begin
                n1_o = p3_i;
                n3_o = p1_i;
                n2_o = p4_i;
                n4_o = p2_i;
            end
            CmdMrrY: begin
                n1_o = p2_i;
                n2_o = p1_i;
                n3_o = p4_i;
                n4_o = p3_i;
            end
            CmdMax: begin
                n1_o = max_all;
                n2_o = max_all;
                n3_o = max_all;
                n4_o = max_all;
            end
            CmdMin: begin
                n1_o = min_all;
                n2_o = min_all;
                n3_o = min_all;
                n4_o = min_all;
            end
            CmdRotCw: begin
                n2_o = p1_i;
                n4_o = p2_i;
                n3_o = p4_i;
                n1_o = p3_i;
            end
            CmdRotCcw: begin
                n1_o = p2_i;
                n2_o = p4_i;
                n4_o = p3_i;
                n3_o = p1_i;
            end
            default: we_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/lcd_ctrl_param.sv
// Parametrised LCD controller: loads an image from IROM, applies 2x2 window
// commands around an operation point, then writes the image back to IRB.
module lcd_ctrl_param import lcd_ctrl_pkg::*; #(
    parameter int unsigned  IMG_W = 8,
    parameter int unsigned  IMG_H = 8,
    parameter int unsigned  DW    = 8,
    localparam int unsigned AW    = $clog2(IMG_W * IMG_H)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [3:0]    cmd,
    input  logic          cmd_valid,
    input  logic [DW-1:0] IROM_Q,
    output logic          IROM_EN,
    output logic [AW-1:0] IROM_A,
    output logic          IRB_RW,
    output logic [DW-1:0] IRB_D,
    output logic [AW-1:0] IRB_A,
    output logic          busy,
    output logic          done
);

    localparam int unsigned   N        = IMG_W * IMG_H;
    localparam int unsigned   XW       = $clog2(IMG_W);
    localparam int unsigned   YW       = $clog2(IMG_H);
    localparam logic [AW-1:0] LastAddr = AW'(N - 1);
    localparam logic [AW-1:0] AOne     = AW'(1);
    localparam logic [XW-1:0] XOne     = XW'(1);
    localparam logic [XW-1:0] XMax     = XW'(IMG_W - 1);
    localparam logic [XW-1:0] XInit    = XW'(IMG_W / 2);
    localparam logic [YW-1:0] YOne     = YW'(1);
    localparam logic [YW-1:0] YMax     = YW'(IMG_H - 1);
    localparam logic [YW-1:0] YInit    = YW'(IMG_H / 2);

    logic [DW-1:0] pix_q [N];

    state_e        state_q, state_d;
    logic [AW-1:0] irom_a_q, irom_a_d;
    logic [AW-1:0] pend_addr_q, pend_addr_d;
    logic          pend_vld_q, pend_vld_d;
    logic          irb_rw_q, irb_rw_d;
    logic [AW-1:0] irb_a_q, irb_a_d;
    logic [DW-1:0] irb_d_q, irb_d_d;
    logic [XW-1:0] op_x_q, op_x_d;
    logic [YW-1:0] op_y_q, op_y_d;

    logic          ld_we, cmd_acc, alu_we;
    logic [AW-1:0] a1, a2, a3, a4;
    logic [DW-1:0] n1, n2, n3, n4;

    // Power-of-two geometry makes y*IMG_W + x a plain concatenation.
    assign a4 = {op_y_q, op_x_q};
    assign a3 = {op_y_q, op_x_q - XOne};
    assign a2 = {op_y_q - YOne, op_x_q};
    assign a1 = {op_y_q - YOne, op_x_q - XOne};

    assign cmd_acc = cmd_valid && (state_q == StIdle);

    lcd_win_alu #(
        .DW (DW)
    ) u_alu (
        .p1_i  (pix_q[a1]),
        .p2_i  (pix_q[a2]),
        .p3_i  (pix_q[a3]),
        .p4_i  (pix_q[a4]),
        .cmd_i (cmd),
        .n1_o  (n1),
        .n2_o  (n2),
        .n3_o  (n3),
        .n4_o  (n4),
        .we_o  (alu_we)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StLoad;
            irom_a_q    <= '0;
            pend_addr_q <= '0;
            pend_vld_q  <= 1'b0;
            irb_rw_q    <= 1'b1;
            irb_a_q     <= '0;
            irb_d_q     <= '0;
            op_x_q      <= XInit;
            op_y_q      <= YInit;
        end else begin
            state_q     <= state_d;
            irom_a_q    <= irom_a_d;
            pend_addr_q <= pend_addr_d;
            pend_vld_q  <= pend_vld_d;
            irb_rw_q    <= irb_rw_d;
            irb_a_q     <= irb_a_d;
            irb_d_q     <= irb_d_d;
            op_x_q      <= op_x_d;
            op_y_q      <= op_y_d;
        end
    end

    // Image buffer survives reset; all four window writes use pre-command values.
    always_ff @(posedge clk) begin
        if (ld_we) begin
            pix_q[pend_addr_q] <= IROM_Q;
        end
        if (cmd_acc && alu_we) begin
            pix_q[a1] <= n1;
            pix_q[a2] <= n2;
            pix_q[a3] <= n3;
            pix_q[a4] <= n4;
        end
    end

    always_comb begin
        state_d     = state_q;
        irom_a_d    = irom_a_q;
        pend_addr_d = irom_a_q;
        pend_vld_d  = 1'b0;
        irb_rw_d    = irb_rw_q;
        irb_a_d     = irb_a_q;
        irb_d_d     = irb_d_q;
        op_x_d      = op_x_q;
        op_y_d      = op_y_q;
        ld_we       = 1'b0;
        unique case (state_q)
            StLoad: begin
                if (irom_a_q != LastAddr) begin
                    irom_a_d = irom_a_q + AOne;
                end
                // IROM data lags its address by one cycle; pend_addr tracks it.
                pend_vld_d = 1'b1;
                if (pend_vld_q) begin
                    ld_we = 1'b1;
                    if (pend_addr_q == LastAddr) begin
                        state_d = StIdle;
                    end
                end
            end
            StIdle: begin
                if (cmd_valid) begin
                    case (cmd)
                        CmdWrtbk: begin
                            state_d  = StWrite;
                            irb_rw_d = 1'b0;
                            irb_a_d  = '0;
                            irb_d_d  = pix_q[0];
                        end
                        CmdUp: if (op_y_q != YOne) op_y_d = op_y_q - YOne;
                        CmdDn: if (op_y_q != YMax) op_y_d = op_y_q + YOne;
                        CmdLf: if (op_x_q != XOne) op_x_d = op_x_q - XOne;
                        CmdRt: if (op_x_q != XMax) op_x_d = op_x_q + XOne;
                        default: ;
                    endcase
                end
            end
            StWrite: begin
                if (irb_a_q == LastAddr) begin
                    irb_rw_d = 1'b1;
                    state_d  = StDone;
                end else begin
                    irb_a_d = irb_a_q + AOne;
                    irb_d_d = pix_q[irb_a_q + AOne];
                end
            end
            StDone: ;
        endcase
    end

    assign IROM_EN = (state_q != StLoad);
    assign IROM_A  = irom_a_q;
    assign IRB_RW  = irb_rw_q;
    assign IRB_A   = irb_a_q;
    assign IRB_D   = irb_d_q;
    assign busy    = (state_q == StLoad) || (state_q == StWrite);
    assign done    = (state_q == StDone);

endmodule

// File: tb/tb_lcd_ctrl_param.sv
// Directed bench for lcd_ctrl_param: an 8x8x8 instance and a 16x4x10 instance
// share one IROM model and stimulus; the unselected instance is held in reset.
module tb_lcd_ctrl_param import lcd_ctrl_pkg::*;;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sel = 1'b0;
    logic [3:0] cmd = 4'd0;
    logic       cmd_valid = 1'b0;

    logic [9:0] rom [64];
    logic [9:0] rom_q;
    logic [9:0] exp_img [64];
    logic [9:0] cap [64];

    int n_checks = 0;
    int n_fail   = 0;

    logic       rst_a, rst_b;
    logic       irom_en_a, irb_rw_a, busy_a, done_a;
    logic [5:0] irom_a_a, irb_a_a;
    logic [7:0] irb_d_a;
    logic       irom_en_b, irb_rw_b, busy_b, done_b;
    logic [5:0] irom_a_b, irb_a_b;
    logic [9:0] irb_d_b;

    logic       irom_en, irb_rw, busy, done;
    logic [5:0] irom_a, irb_a;
    logic [9:0] irb_d;

    assign rst_a   = sel ? 1'b1 : rst;
    assign rst_b   = sel ? rst : 1'b1;
    assign irom_en = sel ? irom_en_b : irom_en_a;
    assign irom_a  = sel ? irom_a_b : irom_a_a;
    assign irb_rw  = sel ? irb_rw_b : irb_rw_a;
    assign irb_a   = sel ? irb_a_b : irb_a_a;
    assign irb_d   = sel ? irb_d_b : {2'b00, irb_d_a};
    assign busy    = sel ? busy_b : busy_a;
    assign done    = sel ? done_b : done_a;

    lcd_ctrl_param #(
        .IMG_W (8),
        .IMG_H (8),
        .DW    (8)
    ) u_dut_a (
        .clk       (clk),
        .reset     (rst_a),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .IROM_Q    (rom_q[7:0]),
        .IROM_EN   (irom_en_a),
        .IROM_A    (irom_a_a),
        .IRB_RW    (irb_rw_a),
        .IRB_D     (irb_d_a),
        .IRB_A     (irb_a_a),
        .busy      (busy_a),
        .done      (done_a)
    );

    lcd_ctrl_param #(
        .IMG_W (16),
        .IMG_H (4),
        .DW    (10)
    ) u_dut_b (
        .clk       (clk),
        .reset     (rst_b),
        .cmd       (cmd),
        .cmd_valid (cmd_valid),
        .IROM_Q    (rom_q),
        .IROM_EN   (irom_en_b),
        .IROM_A    (irom_a_b),
        .IRB_RW    (irb_rw_b),
        .IRB_D     (irb_d_b),
        .IRB_A     (irb_a_b),
        .busy      (busy_b),
        .done      (done_b)
    );

    always #5 clk = ~clk;

    // Synchronous IROM: data valid the cycle after its address.
    always @(posedge clk) begin
        if (!irom_en) rom_q <= rom[irom_a];
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
        end
    endtask

    task automatic set_ramp(input int mul, input int off);
        for (int k = 0; k < 64; k++) begin
            rom[k]     = 10'(k * mul + off);
            exp_img[k] = 10'(k * mul + off);
        end
    endtask

    task automatic set_pix(input int k, input logic [9:0] v_rom, input logic [9:0] v_exp);
        rom[k]     = v_rom;
        exp_img[k] = v_exp;
    endtask

    task automatic send_cmd(input logic [3:0] c);
        cmd       = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic do_load(input bit spam);
        int cyc;
        bit up;
        rst       = 1'b1;
        cmd_valid = 1'b0;
        @(posedge clk);
        #1;
        check_eq("rst_busy", busy, 1);
        check_eq("rst_done", done, 0);
        check_eq("rst_irom_en", irom_en, 0);
        check_eq("rst_irom_a", irom_a, 0);
        check_eq("rst_irb_rw", irb_rw, 1);
        check_eq("rst_irb_a", irb_a, 0);
        check_eq("rst_irb_d", irb_d, 0);
        rst = 1'b0;
        if (spam) begin
            cmd       = CmdAvg;
            cmd_valid = 1'b1;
        end
        cyc = 0;
        up  = 1'b0;
        while (!up && cyc < 200) begin
            @(posedge clk);
            #1;
            cyc++;
            if (!busy) begin
                up = 1'b1;
            end else begin
                check_eq("load_irom_a", irom_a, (cyc < 63) ? cyc : 63);
                check_eq("load_irom_en", irom_en, 0);
            end
        end
        cmd_valid = 1'b0;
        check_eq("load_cycles", cyc, 65);
        check_eq("idle_irom_en", irom_en, 1);
        check_eq("idle_done", done, 0);
    endtask

    task automatic do_wb(input bit spam, input int abort_at);
        int beats, ord_err, guard;
        bit aborted;
        for (int k = 0; k < 64; k++) cap[k] = 'x;
        send_cmd(CmdWrtbk);
        if (spam) begin
            cmd       = CmdAvg;
            cmd_valid = 1'b1;
        end
        check_eq("wb_first_rw", irb_rw, 0);
        check_eq("wb_busy", busy, 1);
        beats   = 0;
        ord_err = 0;
        guard   = 0;
        aborted = 1'b0;
        while (!done && !aborted && guard < 200) begin
            if (irb_rw == 1'b0) begin
                if (int'(irb_a) != beats) ord_err++;
                cap[irb_a] = irb_d;
                beats++;
                if (int'(irb_a) == abort_at) begin
                    rst = 1'b1;
                    #1;
                    check_eq("abort_busy", busy, 1);
                    check_eq("abort_irb_rw", irb_rw, 1);
                    check_eq("abort_irom_a", irom_a, 0);
                    check_eq("abort_done", done, 0);
                    aborted = 1'b1;
                end
            end
            if (!aborted) begin
                @(posedge clk);
                #1;
                guard++;
            end
        end
        if (!aborted) begin
            repeat (3) @(posedge clk);
            #1;
            cmd_valid = 1'b0;
            check_eq("wb_beats", beats, 64);
            check_eq("wb_order_err", ord_err, 0);
            check_eq("done", done, 1);
            check_eq("done_busy", busy, 0);
            check_eq("done_irb_rw", irb_rw, 1);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic check_img(input string tag);
        for (int k = 0; k < 64; k++) begin
            check_eq($sformatf("%s_pix%0d", tag, k), cap[k], exp_img[k]);
        end
    endtask

    initial begin
        sel = 1'b0;

        // Plain load and write-back of a ramp image.
        set_ramp(1, 0);
        do_load(1'b0);
        do_wb(1'b0, -1);
        check_img("ramp");

        // Saturate to (1,1) then average 10,20,30,41 -> 25.
        set_ramp(1, 0);
        set_pix(0, 10, 25);
        set_pix(1, 20, 25);
        set_pix(8, 30, 25);
        set_pix(9, 41, 25);
        do_load(1'b0);
        repeat (5) send_cmd(CmdUp);
        repeat (5) send_cmd(CmdLf);
        check_eq("nav_busy", busy, 0);
        send_cmd(CmdAvg);
        do_wb(1'b0, -1);
        check_img("avg");

        // Rotate clockwise at the default point.
        set_ramp(1, 0);
        set_pix(27, 1, 3);
        set_pix(28, 2, 1);
        set_pix(35, 3, 4);
        set_pix(36, 4, 2);
        do_load(1'b0);
        send_cmd(CmdRotCw);
        do_wb(1'b0, -1);
        check_img("rotcw");

        // CW followed by CCW is the identity.
        set_ramp(1, 0);
        set_pix(27, 1, 1);
        set_pix(28, 2, 2);
        set_pix(35, 3, 3);
        set_pix(36, 4, 4);
        do_load(1'b0);
        send_cmd(CmdRotCw);
        send_cmd(CmdRotCcw);
        do_wb(1'b0, -1);
        check_img("rotccw");

        set_ramp(1, 0);
        set_pix(27, 10'hFF, 10'hFF);
        set_pix(28, 10'h00, 10'hFF);
        set_pix(35, 10'h7F, 10'hFF);
        set_pix(36, 10'h80, 10'hFF);
        do_load(1'b0);
        send_cmd(CmdMax);
        do_wb(1'b0, -1);
        check_img("max");

        set_ramp(1, 0);
        set_pix(27, 10'hFF, 10'h00);
        set_pix(28, 10'h00, 10'h00);
        set_pix(35, 10'h7F, 10'h00);
        set_pix(36, 10'h80, 10'h00);
        do_load(1'b0);
        send_cmd(CmdMin);
        do_wb(1'b0, -1);
        check_img("min");

        // Reserved codes leave the buffer alone.
        set_ramp(1, 0);
        set_pix(27, 10'hFF, 10'hFF);
        set_pix(28, 10'h00, 10'h00);
        set_pix(35, 10'h7F, 10'h7F);
        set_pix(36, 10'h80, 10'h80);
        do_load(1'b0);
        send_cmd(4'd13);
        check_eq("nop_busy", busy, 0);
        send_cmd(4'd12);
        send_cmd(4'd14);
        send_cmd(4'd15);
        do_wb(1'b0, -1);
        check_img("nop");

        // Saturate at (7,7) then mirror in X: rows 6 and 7 swap.
        set_ramp(1, 0);
        set_pix(54, 54, 62);
        set_pix(62, 62, 54);
        set_pix(55, 55, 63);
        set_pix(63, 63, 55);
        do_load(1'b0);
        repeat (5) send_cmd(CmdDn);
        repeat (5) send_cmd(CmdRt);
        send_cmd(CmdMrrX);
        do_wb(1'b0, -1);
        check_img("mrrx");

        // Commands while busy are ignored.
        set_ramp(1, 0);
        do_load(1'b1);
        do_wb(1'b1, -1);
        check_img("busyign");

        // Reset during write-back restarts the load cleanly.
        set_ramp(1, 0);
        do_load(1'b0);
        do_wb(1'b0, 20);
        do_load(1'b0);
        do_wb(1'b0, -1);
        check_img("rstwb");

        // 16x4, 10-bit instance: X saturates at 15, then mirror in Y.
        rst = 1'b1;
        sel = 1'b1;
        set_ramp(11, 300);
        set_pix(30, 10'(30 * 11 + 300), 10'(31 * 11 + 300));
        set_pix(31, 10'(31 * 11 + 300), 10'(30 * 11 + 300));
        set_pix(46, 10'(46 * 11 + 300), 10'(47 * 11 + 300));
        set_pix(47, 10'(47 * 11 + 300), 10'(46 * 11 + 300));
        do_load(1'b0);
        repeat (7) send_cmd(CmdRt);
        send_cmd(CmdRt);
        send_cmd(CmdMrrY);
        do_wb(1'b0, -1);
        check_img("w16");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
